// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: word-addressed store with a fixed miss
// latency and a one-entry last-word buffer that completes repeat accesses in one cycle.
module dmem_responder #(
  parameter int LATENCY    = 4,
  parameter int DEPTH_LOG2 = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] Addr,
  input  logic [15:0] DataIn,
  input  logic        Rd,
  input  logic        Wr,
  output logic [15:0] DataOut,
  output logic        Done,
  output logic        Stall,
  output logic        Hit,
  output logic        Err,
  output logic        Req
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] BUSY     = 2'd1;
  localparam logic [1:0] DONE     = 2'd2;
  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  logic [1:0]            state_r;
  logic [1:0]            nextState_s;
  logic [3:0]            cnt_r;
  logic [3:0]            nextCnt_s;
  logic [14:0]           word_r;
  logic [15:0]           data_r;
  logic                  wr_r;
  logic                  bufValid_r;
  logic [14:0]           bufTag_r;
  logic [15:0]           store_r [2**DEPTH_LOG2];

  logic                  accept_s;
  logic                  isErr_s;
  logic                  isHit_s;
  logic                  complete_s;
  logic                  complWr_s;
  logic [14:0]           complWord_s;
  logic [15:0]           complData_s;
  logic [DEPTH_LOG2-1:0] complIdx_s;

  // Next-state, acceptance classification and selection of the access that completes this edge
  always_comb begin
    accept_s    = (state_r != BUSY) && (Rd || Wr);
    isErr_s     = accept_s && Addr[0];
    isHit_s     = accept_s && !Addr[0] && bufValid_r && (Addr[15:1] == bufTag_r);
    nextState_s = state_r;
    nextCnt_s   = cnt_r;
    complete_s  = 1'b0;
    complWord_s = word_r;
    complData_s = data_r;
    complWr_s   = wr_r;
    case (state_r)
      IDLE, DONE: begin
        if (accept_s) begin
          complWord_s = Addr[15:1];
          complData_s = DataIn;
          complWr_s   = Wr;
          if (isErr_s || isHit_s) begin
            nextState_s = DONE;
            nextCnt_s   = 4'd0;
            complete_s  = isHit_s;
          end else begin
            nextState_s = BUSY;
            nextCnt_s   = CNT_LOAD;
          end
        end else begin
          nextState_s = IDLE;
          nextCnt_s   = 4'd0;
        end
      end
      BUSY: begin
        if (cnt_r == 4'd1) begin
          nextState_s = DONE;
          nextCnt_s   = 4'd0;
          complete_s  = 1'b1;
        end else begin
          nextCnt_s   = cnt_r - 4'd1;
        end
      end
      default: begin
        nextState_s = IDLE;
        nextCnt_s   = 4'd0;
      end
    endcase
    complIdx_s = complWord_s[DEPTH_LOG2-1:0];
  end

  // Control state, registered outputs, latched request and last-word buffer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      cnt_r      <= 4'd0;
      word_r     <= 15'd0;
      data_r     <= 16'd0;
      wr_r       <= 1'b0;
      bufValid_r <= 1'b0;
      bufTag_r   <= 15'd0;
      DataOut    <= 16'd0;
      Done       <= 1'b0;
      Stall      <= 1'b0;
      Hit        <= 1'b0;
      Err        <= 1'b0;
      Req        <= 1'b0;
    end else begin
      state_r <= nextState_s;
      cnt_r   <= nextCnt_s;
      Req     <= accept_s;
      Stall   <= (nextState_s == BUSY);
      Done    <= complete_s || isErr_s;
      Hit     <= isHit_s;
      Err     <= isErr_s;
      if (accept_s) begin
        word_r <= Addr[15:1];
        data_r <= DataIn;
        wr_r   <= Wr;
      end
      // Error completions leave both the buffer and DataOut untouched
      if (complete_s) begin
        bufValid_r <= 1'b1;
        bufTag_r   <= complWord_s;
        if (!complWr_s) begin
          DataOut <= store_r[complIdx_s];
        end
      end
    end
  end

  // Backing store write port; contents deliberately survive reset
  always_ff @(posedge clk) begin
    if (complete_s && complWr_s) begin
      store_r[complIdx_s] <= complData_s;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: a transaction-level timing model is
// compared every cycle, plus directed literal checks from the test plan.
module tb_dmem_responder;

  localparam int LAT = 4;
  localparam int DL2 = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] Addr;
  logic [15:0] DataIn;
  logic        Rd;
  logic        Wr;
  logic [15:0] DataOut;
  logic        Done;
  logic        Stall;
  logic        Hit;
  logic        Err;
  logic        Req;

  dmem_responder #(.LATENCY(LAT), .DEPTH_LOG2(DL2)) dut (
    .clk(clk), .rst(rst), .Addr(Addr), .DataIn(DataIn), .Rd(Rd), .Wr(Wr),
    .DataOut(DataOut), .Done(Done), .Stall(Stall), .Hit(Hit), .Err(Err), .Req(Req)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Model: each accepted access is scheduled as {accept cycle, completion cycle}
  int          cyc = 0;
  int          prevCyc;
  bit          modelOn = 1'b0;
  bit          pend = 1'b0;
  int          pDone;
  logic [15:0] pAddr;
  logic [15:0] pData;
  bit          pWr, pHit, pErr, acc;
  bit          bufV = 1'b0;
  logic [14:0] bufTag;
  logic [15:0] mm  [2**DL2];
  bit          mmK [2**DL2];
  int          idx;
  logic        eDone, eStall, eReq, eHit, eErr;
  logic [15:0] eData;
  bit          eDataK;

  always @(posedge clk or posedge rst) begin
    cyc = cyc + 1;
    if (rst) begin
      pend = 1'b0; bufV = 1'b0;
      eDone = 1'b0; eStall = 1'b0; eReq = 1'b0; eHit = 1'b0; eErr = 1'b0;
      eData = 16'h0000; eDataK = 1'b1;
    end else begin
      prevCyc = cyc - 1;
      acc = (Rd || Wr) && !(pend && prevCyc < pDone);
      eReq = acc; eDone = 1'b0; eHit = 1'b0; eErr = 1'b0;
      if (acc) begin
        pend  = 1'b1;
        pAddr = Addr; pData = DataIn; pWr = Wr;
        pErr  = Addr[0];
        pHit  = !Addr[0] && bufV && (bufTag == Addr[15:1]);
        pDone = prevCyc + ((pErr || pHit) ? 1 : LAT);
      end
      eStall = pend && (cyc < pDone);
      if (pend && cyc == pDone) begin
        eDone = 1'b1; eHit = pHit; eErr = pErr;
        if (!pErr) begin
          idx = int'(pAddr[DL2:1]);
          if (pWr) begin
            mm[idx] = pData; mmK[idx] = 1'b1;
          end else begin
            eData = mm[idx]; eDataK = mmK[idx];
          end
          bufV = 1'b1; bufTag = pAddr[15:1];
        end
        pend = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (modelOn) begin
      chk("cyc_Done", Done, eDone);
      chk("cyc_Stall", Stall, eStall);
      chk("cyc_Req", Req, eReq);
      chk("cyc_Hit", Hit, eHit);
      chk("cyc_Err", Err, eErr);
      if (eDataK) chk("cyc_DataOut", DataOut, eData);
    end
  end

  int reqCyc;
  int lat;

  task automatic doReq(input logic r, input logic w, input logic [15:0] a, input logic [15:0] d);
    @(posedge clk); #1;
    Rd = r; Wr = w; Addr = a; DataIn = d;
    reqCyc = cyc;
    @(posedge clk); #1;
    Rd = 1'b0; Wr = 1'b0;
  endtask

  task automatic waitDone(output int l);
    l = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (Done === 1'b1) begin
        l = cyc - reqCyc;
        return;
      end
    end
    chk("done_timeout", 32'd0, 32'd1);
  endtask

  int c0, nd, reqCnt, doneCnt;
  int dc [3];

  initial begin
    Rd = 1'b0; Wr = 1'b0; Addr = 16'h0000; DataIn = 16'h0000; rst = 1'b0;
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0; modelOn = 1'b1;
    @(negedge clk);
    chk("rst_Done", Done, 1'b0);
    chk("rst_Stall", Stall, 1'b0);
    chk("rst_Req", Req, 1'b0);
    chk("rst_DataOut", DataOut, 16'h0000);

    // Cold read miss
    doReq(1'b1, 1'b0, 16'h0010, 16'h0000);
    @(negedge clk);
    chk("miss_req_c1", Req, 1'b1);
    chk("miss_stall_c1", Stall, 1'b1);
    waitDone(lat);
    chk("miss_lat", lat, 32'd4);
    chk("miss_hit", Hit, 1'b0);

    // Write miss then read hit of the same word
    doReq(1'b0, 1'b1, 16'h0020, 16'hBEEF);
    waitDone(lat);
    chk("wr_miss_lat", lat, 32'd4);
    doReq(1'b1, 1'b0, 16'h0020, 16'h0000);
    waitDone(lat);
    chk("rd_hit_lat", lat, 32'd1);
    chk("rd_hit_hit", Hit, 1'b1);
    chk("rd_hit_data", DataOut, 16'hBEEF);

    // Misaligned access then aligned neighbour
    doReq(1'b1, 1'b0, 16'h0031, 16'h0000);
    waitDone(lat);
    chk("err_lat", lat, 32'd1);
    chk("err_err", Err, 1'b1);
    chk("err_hit", Hit, 1'b0);
    chk("err_data_held", DataOut, 16'hBEEF);
    doReq(1'b1, 1'b0, 16'h0030, 16'h0000);
    waitDone(lat);
    chk("after_err_lat", lat, 32'd4);

    // Rd held on one address: miss, then back-to-back hits
    @(posedge clk); #1;
    Rd = 1'b1; Addr = 16'h0040; c0 = cyc; nd = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (Done === 1'b1) begin
        if (nd < 3) dc[nd] = cyc;
        nd++;
      end
      @(posedge clk); #1;
      if (cyc == c0 + 6) Rd = 1'b0;
    end
    chk("b2b_count", nd, 32'd3);
    chk("b2b_d0", dc[0] - c0, 32'd4);
    chk("b2b_d1", dc[1] - c0, 32'd5);
    chk("b2b_d2", dc[2] - c0, 32'd6);

    // Reset during BUSY abandons the write
    doReq(1'b0, 1'b1, 16'h0050, 16'h5555);
    waitDone(lat);
    doReq(1'b1, 1'b0, 16'h0052, 16'h0000);
    waitDone(lat);
    doReq(1'b0, 1'b1, 16'h0050, 16'h1234);
    @(posedge clk); #2;
    rst = 1'b1;
    @(negedge clk);
    chk("rstbusy_Done", Done, 1'b0);
    chk("rstbusy_Stall", Stall, 1'b0);
    chk("rstbusy_Req", Req, 1'b0);
    chk("rstbusy_DataOut", DataOut, 16'h0000);
    @(posedge clk); #1;
    rst = 1'b0;
    doReq(1'b1, 1'b0, 16'h0050, 16'h0000);
    waitDone(lat);
    chk("rstbusy_rd_lat", lat, 32'd4);
    chk("rstbusy_rd_data", DataOut, 16'h5555);

    // Reset in the DONE cycle keeps the committed write
    doReq(1'b0, 1'b1, 16'h0054, 16'h7777);
    waitDone(lat);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    doReq(1'b1, 1'b0, 16'h0054, 16'h0000);
    waitDone(lat);
    chk("rstdone_rd_lat", lat, 32'd4);
    chk("rstdone_rd_data", DataOut, 16'h7777);

    // Rd&Wr is a write; Rd toggling during BUSY is dropped
    doReq(1'b1, 1'b1, 16'h0060, 16'h00AA);
    reqCnt = 1; doneCnt = 0;
    for (int k = 1; k <= 7; k++) begin
      Rd = (k == 1 || k == 3);
      @(negedge clk);
      if (k > 1) reqCnt += int'(Req);
      doneCnt += int'(Done);
      @(posedge clk); #1;
    end
    Rd = 1'b0;
    chk("toggle_req_count", reqCnt, 32'd1);
    chk("toggle_done_count", doneCnt, 32'd1);
    doReq(1'b1, 1'b0, 16'h0060, 16'h0000);
    waitDone(lat);
    chk("rdwr_hit_lat", lat, 32'd1);
    chk("rdwr_data", DataOut, 16'h00AA);
    doReq(1'b1, 1'b0, 16'h0260, 16'h0000);
    waitDone(lat);
    chk("alias_lat", lat, 32'd4);
    chk("alias_hit", Hit, 1'b0);
    chk("alias_data", DataOut, 16'h00AA);

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Multi-cycle data-memory responder serving the processor's memory-stage request interface (Rd/Wr/Addr/DataIn in; DataOut/Done/Stall out). Models a word-addressed backing store with configurable miss latency plus a one-entry last-word buffer that completes repeat accesses in one cycle. It emits per-access Req and Hit pulses for the bench's request and hit counters, and is the responder counterpart of the pipeline's dmem initiator.

## Interface
- LATENCY, 4: miss latency in cycles from request acceptance to Done; legal range 2..15
- DEPTH_LOG2, 8: backing store holds 2^DEPTH_LOG2 16-bit words
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  reset, asynchronous, active-high
- Addr  in  16  byte address; word index = Addr[DEPTH_LOG2:1], higher bits alias
- DataIn  in  16  write data
- Rd  in  1  read request
- Wr  in  1  write request; Rd&Wr both high is a write
- DataOut  out  16  read data, valid only while Done=1 for a read
- Done  out  1  one-cycle completion pulse
- Stall  out  1  responder busy; requests ignored while high
- Hit  out  1  completion came from last-word buffer; valid with Done
- Err  out  1  misaligned access (Addr[0]=1); valid with Done
- Req  out  1  one-cycle pulse in the cycle after a request is accepted

## Operation
- States: IDLE, BUSY, DONE. Request = Rd|Wr.
- Acceptance: request sampled at a rising edge while state is IDLE or DONE. Addr, DataIn, write flag latched; Req=1 next cycle.
- Accept classification, in priority order:
  - Addr[0]=1: go to DONE with Err=1, Hit=0. No memory write, no buffer update.
  - Buffer valid and Addr[15:1]==tag: go to DONE with Hit=1.
  - Otherwise: go to BUSY with down-counter loaded to LATENCY-1.
- BUSY: Stall=1; counter decrements each cycle; at counter==1 the next edge enters DONE. Rd/Wr ignored throughout.
- DONE: Done=1 for exactly one cycle. Accepts a new request (back-to-back); otherwise returns to IDLE.
- Writes commit to the store on the edge entering DONE (hit or miss, never on Err).
- Reads: DataOut = store word at that same edge. Read-after-write to the same word returns the new data.
- Buffer: on each non-error completion, tag <= Addr[15:1], valid <= 1. Both reads and writes allocate.
- DataOut holds its last value outside Done; Hit and Err are 0 outside Done.

## Timing
- Reset (async): state IDLE; Done, Stall, Hit, Err, Req = 0; DataOut = 0; buffer valid = 0; counter = 0.
- Store contents are not reset.
- Hit or Err latency: Done in the cycle immediately after acceptance (1 cycle).
- Miss latency: Stall high for LATENCY-1 cycles, then Done. Done arrives LATENCY cycles after acceptance.
- Back-to-back: a request present during the Done cycle is accepted at the edge ending it. Done may be high on consecutive cycles for consecutive hits.
- Reset during BUSY: access abandoned, no write committed, no Done issued.
- Reset asserted in the DONE cycle: the write already committed stays.
- Requests during BUSY are dropped; no queueing.
- Tag compares the full Addr[15:1], so aliased addresses miss the buffer even though they map to the same store word.

## Test plan
- Reset, then read 0x0010 with LATENCY=4 -> Req=1 at cycle 1, Stall=1 cycles 1-3, Done=1 and Hit=0 at cycle 4.
- Write 0xBEEF to 0x0020 (miss), then read 0x0020 -> second access has Done 1 cycle after acceptance, Hit=1, DataOut=0xBEEF.
- Read 0x0031 -> Done 1 cycle after acceptance with Err=1, Hit=0. Store unchanged. A following read of 0x0030 is a miss (4 cycles).
- Three consecutive reads of 0x0040 held on Rd -> first completes at 4 cycles, then Done on consecutive cycles with Hit=1.
- Write 0x1234 to 0x0050, assert rst during the second BUSY cycle -> all outputs 0 immediately. A post-reset read of 0x0050 misses and returns the prior contents, not 0x1234.
- Rd&Wr both high, Addr 0x0060, DataIn 0x00AA -> treated as a write. A later read returns 0x00AA. Toggling Rd during BUSY produces no extra Req or Done.
